// File: rtl/mem_stage_pkg.sv
// Shared types and byte-lane constants for the ARM memory stage.
// Imported by the bus interface, the lane aligner and the stage top.
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int BUS_W = 32;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  function automatic logic is_one_hot(input logic [3:0] be);
    return (be == 4'b0001) || (be == 4'b0010) || (be == 4'b0100) || (be == 4'b1000);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Request/acknowledge data-memory bus between the memory stage and the data memory.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic             mem_req;
  logic             mem_we;
  logic [BUS_W-1:0] mem_addr;
  logic [BUS_W-1:0] mem_wdata;
  logic [3:0]       mem_be;
  logic             mem_ack;
  logic [BUS_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/mem_stage_load_align.sv
// Byte-lane handling: replicates store data across lanes and extracts
// zero-extended load data, both steered by the access byte-enable mask.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]       be,
  input  logic [BUS_W-1:0] store_data,
  input  logic [BUS_W-1:0] rdata,
  output logic [BUS_W-1:0] store_lanes,
  output logic [BUS_W-1:0] load_data
);

  always_comb begin
    store_lanes = store_data;
    load_data   = rdata;
    if (is_one_hot(be)) begin
      store_lanes = {4{store_data[7:0]}};
      unique case (be)
        4'b0001: load_data = {24'h0, rdata[7:0]};
        4'b0010: load_data = {24'h0, rdata[15:8]};
        4'b0100: load_data = {24'h0, rdata[23:16]};
        default: load_data = {24'h0, rdata[31:24]};
      endcase
    end else if (be == BE_HALF_LO) begin
      store_lanes = {2{store_data[15:0]}};
      load_data   = {16'h0, rdata[15:0]};
    end else if (be == BE_HALF_HI) begin
      store_lanes = {2{store_data[15:0]}};
      load_data   = {16'h0, rdata[31:16]};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the pipelined ARM core: E/M register, bounded-wait
// data-memory access controller, lane alignment and the M/W register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic              MemWriteE,
  input  logic [3:0]        RdE,
  input  logic [DATA_W-1:0] ALUResultE,
  input  logic [DATA_W-1:0] WriteDataE,
  input  logic [3:0]        byteEnableE,
  mem_stage_if.master       bus,
  output logic              StallM,
  output logic [DATA_W-1:0] ALUResultM,
  output logic              RegWriteM,
  output logic [3:0]        RdM,
  output logic              RegWriteW,
  output logic              MemtoRegW,
  output logic [3:0]        RdW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [DATA_W-1:0] ALUOutW,
  output logic [DATA_W-1:0] ResultW,
  output logic              bus_error
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic              memtoreg_m;
  logic              memwrite_m;
  logic [DATA_W-1:0] wdata_m;
  logic [3:0]        be_m;
  logic              memop_m;
  logic              timeout;
  logic              set_err;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] store_lanes;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteM  <= 1'b0;
      memtoreg_m <= 1'b0;
      memwrite_m <= 1'b0;
      RdM        <= '0;
      ALUResultM <= '0;
      wdata_m    <= '0;
      be_m       <= '0;
    end else if (!StallM) begin
      RegWriteM  <= RegWriteE;
      memtoreg_m <= MemtoRegE;
      memwrite_m <= MemWriteE;
      RdM        <= RdE;
      ALUResultM <= ALUResultE;
      wdata_m    <= WriteDataE;
      be_m       <= byteEnableE;
    end
  end

  // A load whose condition failed has RegWrite cleared and makes no access.
  assign memop_m = memwrite_m | (memtoreg_m & RegWriteM);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bus_error <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (set_err) bus_error <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    set_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (memop_m && !bus.mem_ack) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      default: begin
        if (bus.mem_ack) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
          set_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    timeout     = (state_q == WAIT) && (cnt_q == CNT_MAX) && !bus.mem_ack;
    StallM      = memop_m && !bus.mem_ack && !timeout;
    bus.mem_req = memop_m;
  end

  load_align u_align (
    .be          (be_m),
    .store_data  (wdata_m),
    .rdata       (bus.mem_rdata),
    .store_lanes (store_lanes),
    .load_data   (load_data)
  );

  assign bus.mem_we    = memwrite_m;
  assign bus.mem_addr  = {ALUResultM[DATA_W-1:2], 2'b00};
  assign bus.mem_be    = be_m;
  assign bus.mem_wdata = store_lanes;

  // Stalled cycles push bubbles; a timed-out access retires without writing.
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      RdW       <= '0;
      ReadDataW <= '0;
      ALUOutW   <= '0;
    end else if (StallM) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
    end else begin
      RegWriteW <= RegWriteM && !timeout;
      MemtoRegW <= memtoreg_m;
      RdW       <= RdM;
      ALUOutW   <= ALUResultM;
      ReadDataW <= (memop_m && bus.mem_ack) ? load_data : '0;
    end
  end

  assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, zero-wait and waited
// accesses, lane handling, bus timeout and reset during a wait.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk;
  logic        reset;
  logic        RegWriteE, MemtoRegE, MemWriteE;
  logic [3:0]  RdE;
  logic [31:0] ALUResultE, WriteDataE;
  logic [3:0]  byteEnableE;
  logic        StallM, RegWriteM, RegWriteW, MemtoRegW, bus_error;
  logic [3:0]  RdM, RdW;
  logic [31:0] ALUResultM, ReadDataW, ALUOutW, ResultW;

  int vectorCount = 0;
  int missCount   = 0;
  int stallCount;

  mem_stage_if bus ();

  mem_stage #(.MAX_WAIT(15), .DATA_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .RegWriteE   (RegWriteE),
    .MemtoRegE   (MemtoRegE),
    .MemWriteE   (MemWriteE),
    .RdE         (RdE),
    .ALUResultE  (ALUResultE),
    .WriteDataE  (WriteDataE),
    .byteEnableE (byteEnableE),
    .bus         (bus),
    .StallM      (StallM),
    .ALUResultM  (ALUResultM),
    .RegWriteM   (RegWriteM),
    .RdM         (RdM),
    .RegWriteW   (RegWriteW),
    .MemtoRegW   (MemtoRegW),
    .RdW         (RdW),
    .ReadDataW   (ReadDataW),
    .ALUOutW     (ALUOutW),
    .ResultW     (ResultW),
    .bus_error   (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic rw, input logic m2r, input logic mw,
                               input logic [3:0] rd, input logic [31:0] alu,
                               input logic [31:0] wd, input logic [3:0] be);
    RegWriteE   = rw;
    MemtoRegE   = m2r;
    MemWriteE   = mw;
    RdE         = rd;
    ALUResultE  = alu;
    WriteDataE  = wd;
    byteEnableE = be;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tick();
    checkOutput("rst_req", {31'b0, bus.mem_req}, 0);
    checkOutput("rst_stall", {31'b0, StallM}, 0);
    checkOutput("rst_regwritew", {31'b0, RegWriteW}, 0);
    checkOutput("rst_resultw", ResultW, 0);
    checkOutput("rst_buserr", {31'b0, bus_error}, 0);
    reset = 1'b0;

    // ALU op passes through without touching memory
    applyStimulus(1, 0, 0, 4'd3, 32'h1234, 0, BE_WORD);
    tick();
    checkOutput("alu_req", {31'b0, bus.mem_req}, 0);
    checkOutput("alu_stall", {31'b0, StallM}, 0);
    checkOutput("alu_resm", ALUResultM, 32'h1234);
    checkOutput("alu_rdm", {28'b0, RdM}, 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("alu_regwritew", {31'b0, RegWriteW}, 1);
    checkOutput("alu_rdw", {28'b0, RdW}, 3);
    checkOutput("alu_resultw", ResultW, 32'h1234);

    // Zero-wait word load
    applyStimulus(1, 1, 0, 4'd5, 32'h100, 0, BE_WORD);
    tick();
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    #1;
    checkOutput("ldw_req", {31'b0, bus.mem_req}, 1);
    checkOutput("ldw_addr", bus.mem_addr, 32'h100);
    checkOutput("ldw_be", {28'b0, bus.mem_be}, 4'b1111);
    checkOutput("ldw_stall", {31'b0, StallM}, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    bus.mem_ack = 1'b0;
    checkOutput("ldw_readdataw", ReadDataW, 32'hDEADBEEF);
    checkOutput("ldw_resultw", ResultW, 32'hDEADBEEF);
    checkOutput("ldw_rdw", {28'b0, RdW}, 5);

    // Byte store acknowledged after three wait cycles
    applyStimulus(0, 0, 1, 0, 32'h203, 32'h000000A5, 4'b0100);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("stb_wdata", bus.mem_wdata, 32'hA5A5A5A5);
    checkOutput("stb_we", {31'b0, bus.mem_we}, 1);
    checkOutput("stb_addr", bus.mem_addr, 32'h200);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) bus.mem_ack = 1'b1;
      #1;
      checkOutput($sformatf("stb_stall%0d", c), {31'b0, StallM}, (c < 3) ? 32'd1 : 32'd0);
      if (c > 0) checkOutput($sformatf("stb_bubble%0d", c), {31'b0, RegWriteW}, 0);
      tick();
    end
    bus.mem_ack = 1'b0;
    checkOutput("stb_buserr", {31'b0, bus_error}, 0);

    // Halfword load from the upper lane
    applyStimulus(1, 1, 0, 4'd7, 32'h302, 0, BE_HALF_HI);
    tick();
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hCAFE0011;
    #1;
    checkOutput("ldh_addr", bus.mem_addr, 32'h300);
    applyStimulus(1, 1, 0, 4'd8, 32'h101, 0, 4'b0010);
    tick();
    checkOutput("ldh_readdataw", ReadDataW, 32'h0000CAFE);
    checkOutput("ldh_rdw", {28'b0, RdW}, 7);

    // Byte load from lane 1 (ack still high)
    bus.mem_rdata = 32'h11223344;
    applyStimulus(0, 0, 1, 0, 32'h40, 32'h1234BEEF, BE_HALF_LO);
    tick();
    checkOutput("ldb_readdataw", ReadDataW, 32'h00000033);
    #1;
    checkOutput("sth_wdata", bus.mem_wdata, 32'hBEEFBEEF);
    checkOutput("sth_be", {28'b0, bus.mem_be}, 4'b0011);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    bus.mem_ack = 1'b0;

    // Load that never completes times out after MAX_WAIT stalled cycles
    applyStimulus(1, 1, 0, 4'd9, 32'h400, 0, BE_WORD);
    tick();
    applyStimulus(1, 0, 0, 4'd10, 32'h55, 0, BE_WORD);
    stallCount = 0;
    for (int c = 0; c < 40; c++) begin
      if (!StallM) break;
      stallCount++;
      tick();
    end
    checkOutput("to_stallcycles", stallCount, 15);
    checkOutput("to_buserr_pre", {31'b0, bus_error}, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("to_buserr", {31'b0, bus_error}, 1);
    checkOutput("to_regwritew", {31'b0, RegWriteW}, 0);
    checkOutput("to_readdataw", ReadDataW, 0);
    checkOutput("to_next_rdm", {28'b0, RdM}, 10);
    checkOutput("to_next_stall", {31'b0, StallM}, 0);
    tick();
    checkOutput("to_next_regwritew", {31'b0, RegWriteW}, 1);
    checkOutput("to_next_resultw", ResultW, 32'h55);

    // Reset during WAIT cycle 2, then a stray ack
    applyStimulus(1, 1, 0, 4'd11, 32'h500, 0, BE_WORD);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checkOutput("rw_req_pre", {31'b0, bus.mem_req}, 1);
    checkOutput("rw_stall_pre", {31'b0, StallM}, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rw_req", {31'b0, bus.mem_req}, 0);
    checkOutput("rw_stall", {31'b0, StallM}, 0);
    checkOutput("rw_addr", bus.mem_addr, 0);
    checkOutput("rw_resm", ALUResultM, 0);
    checkOutput("rw_buserr", {31'b0, bus_error}, 0);
    checkOutput("rw_resultw", ResultW, 0);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hFFFFFFFF;
    tick();
    bus.mem_ack = 1'b0;
    checkOutput("rw_late_req", {31'b0, bus.mem_req}, 0);
    checkOutput("rw_late_regwritew", {31'b0, RegWriteW}, 0);
    checkOutput("rw_late_readdataw", ReadDataW, 0);
    checkOutput("rw_late_stall", {31'b0, StallM}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
